// File: rtl/aes128_sbox_arbiter.sv
// Time-shares one external Rijndael S-box between SubBytes (16 B) and SubWord (4 B) bursts.
// Build option AES128_SBOX_ARB_RR_EN: round-robin tie-break; undefined gives KS fixed priority.
module aes128_sbox_arbiter #(
   parameter int unsigned N_SB_BYTES = 16,
   parameter int unsigned N_KS_BYTES = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       sb_req_i,
   input  logic [N_SB_BYTES-1:0][7:0] sb_data_i,
   output logic                       sb_gnt_o,
   output logic                       sb_valid_o,
   output logic [3:0]                 sb_addr_o,
   output logic [7:0]                 sb_data_o,
   output logic                       sb_done_o,
   input  logic                       ks_req_i,
   input  logic [N_KS_BYTES-1:0][7:0] ks_data_i,
   output logic                       ks_gnt_o,
   output logic                       ks_valid_o,
   output logic [1:0]                 ks_addr_o,
   output logic [7:0]                 ks_data_o,
   output logic                       ks_done_o,
   output logic [7:0]                 sbox_sub_o,
   input  logic [7:0]                 sbox_sub_i
);

   typedef enum logic [1:0] {StIdle, StSbRun, StKsRun} state_e;

   localparam logic [3:0] SbLast = 4'(N_SB_BYTES - 1);
   localparam logic [3:0] KsLast = 4'(N_KS_BYTES - 1);

   state_e     state_q;
   logic [3:0] cnt_q;
   logic       ks_wins_tie;
   logic       sb_run;
   logic       ks_run;

`ifdef AES128_SBOX_ARB_RR_EN
   logic last_owner_q;  // 1: KS owned the most recent burst
   assign ks_wins_tie = ~last_owner_q;
`else
   assign ks_wins_tie = 1'b1;
`endif

   assign sb_run = (state_q == StSbRun);
   assign ks_run = (state_q == StKsRun);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
`ifdef AES128_SBOX_ARB_RR_EN
         last_owner_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (sb_req_i && ks_req_i) begin
                  state_q <= ks_wins_tie ? StKsRun : StSbRun;
               end else if (sb_req_i) begin
                  state_q <= StSbRun;
               end else if (ks_req_i) begin
                  state_q <= StKsRun;
               end
            end
            StSbRun: begin
               if (cnt_q == SbLast) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
`ifdef AES128_SBOX_ARB_RR_EN
                  last_owner_q <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StKsRun: begin
               if (cnt_q == KsLast) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
`ifdef AES128_SBOX_ARB_RR_EN
                  last_owner_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // S-box result is passed straight through; only the owner's outputs are ever non-zero.
   always_comb begin
      sb_gnt_o   = 1'b0;
      sb_valid_o = 1'b0;
      sb_addr_o  = '0;
      sb_data_o  = '0;
      sb_done_o  = 1'b0;
      ks_gnt_o   = 1'b0;
      ks_valid_o = 1'b0;
      ks_addr_o  = '0;
      ks_data_o  = '0;
      ks_done_o  = 1'b0;
      sbox_sub_o = '0;
      if (sb_run) begin
         sbox_sub_o = sb_data_i[cnt_q];
         sb_gnt_o   = 1'b1;
         sb_valid_o = 1'b1;
         sb_addr_o  = cnt_q;
         sb_data_o  = sbox_sub_i;
         sb_done_o  = (cnt_q == SbLast);
      end else if (ks_run) begin
         sbox_sub_o = ks_data_i[cnt_q[1:0]];
         ks_gnt_o   = 1'b1;
         ks_valid_o = 1'b1;
         ks_addr_o  = cnt_q[1:0];
         ks_data_o  = sbox_sub_i;
         ks_done_o  = (cnt_q == KsLast);
      end
   end

endmodule

// File: doc/aes128_sbox_arbiter.md
# aes128_sbox_arbiter

Time-shares one Rijndael S-box between the SubBytes stage (16-byte state) and the key-expansion SubWord step (4-byte word). Each requester presents its packed input bytes plus a request. The arbiter grants one requester at a time and streams that requester's bytes through the S-box, one byte per cycle, returning each substituted byte with its index. It sits between the round controller's datapath stages and the single S-box instance, which lives outside the block and is accessed combinationally.

## Interface
- N_SB_BYTES, 16, byte count of a SubBytes burst (≤16)
- N_KS_BYTES, 4, byte count of a SubWord burst (≤4)

- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- sb_req_i  in  1  SubBytes request, level
- sb_data_i  in  [N_SB_BYTES-1:0][7:0]  SubBytes input bytes, held stable while sb_req_i/sb_gnt_o
- sb_gnt_o  out  1  SubBytes burst in progress
- sb_valid_o  out  1  sb_data_o/sb_addr_o valid
- sb_addr_o  out  4  index of byte on sb_data_o
- sb_data_o  out  8  substituted byte
- sb_done_o  out  1  last byte of SubBytes burst this cycle
- ks_req_i, ks_data_i [N_KS_BYTES-1:0][7:0], ks_gnt_o, ks_valid_o, ks_addr_o (2), ks_data_o (8), ks_done_o: same semantics for SubWord
- sbox_sub_o  out  8  byte to external S-box
- sbox_sub_i  in  8  S-box result, combinational from sbox_sub_o

## Operation
- FSM states: IDLE, SB_RUN, KS_RUN. Byte counter cnt (4 bit). Owner register last_owner.
- IDLE: arbitrate on sampled requests:
  - one request high → go to that RUN state;
  - both high → winner per Configuration;
  - none → stay.
- cnt is 0 on entry to RUN.
- RUN (owner X):
  - sbox_sub_o = X_data_i[cnt];
  - X_data_o = sbox_sub_i;
  - X_addr_o = cnt; X_valid_o = 1; X_gnt_o = 1;
  - cnt increments each cycle.
- cnt == N_X_BYTES-1: X_done_o = 1 (combinational, same cycle as last valid byte). Next state IDLE, cnt ← 0, last_owner ← X.
- Non-owner outputs stay 0 throughout.
- Request deasserted mid-burst: ignored, burst runs to completion (no abort).
- Requester must drop req on the clock edge that samples done. A req still high in IDLE starts a new burst.
- Reset (any time, incl. mid-burst): state IDLE, cnt 0, last_owner SB. No done is emitted for the aborted burst.
- Outputs in IDLE/reset: all gnt/valid/done 0, addr 0, data 0, sbox_sub_o 0.

## Timing
- Request high before edge k (IDLE) → RUN cycles k..k+N-1 → done in cycle k+N-1 → IDLE in cycle k+N.
- SubBytes burst: 16 valid cycles. SubWord burst: 4 valid cycles.
- Minimum one IDLE cycle between any two bursts; arbitration happens only in IDLE.
- Worst-case wait for a requester: one full burst of the other requester + 1 IDLE cycle (with RR), unbounded for SB under fixed priority if KS re-requests continuously.
- Output data path: combinational sbox_sub_i → X_data_o, no register.

## Configuration
- AES128_SBOX_ARB_RR_EN undefined: fixed priority, KS wins every tie.
- AES128_SBOX_ARB_RR_EN defined: round-robin. A tie is won by the requester other than last_owner. last_owner resets to SB, so the first tie after reset goes to KS.
- Single-request behaviour is identical in both builds.

## Test plan
- SB only, sb_data_i byte0=0x00, byte1=0x01, byte15=0x53 → sb_valid_o for 16 cycles, addr 0..15. Data: 0x63 at addr0, 0x7c at addr1, 0xed at addr15. sb_done_o only with addr 15. ks_* all 0.
- KS only, word bytes 0x00,0x01,0x53,0x00 → 4 valid cycles, data 0x63,0x7c,0xed,0x63, ks_done_o with addr 3, IDLE next cycle.
- Both held high continuously, no macro → KS, IDLE, KS, … SB never granted.
- Same stimulus with macro → KS(4), IDLE, SB(16), IDLE, KS, … alternation.
- sb_req_i dropped at cycle 3 of burst → burst still produces all 16 bytes and done.
- rst_n_i pulsed low asynchronously at SB byte 7 → all outputs 0 immediately. No done. The next SB request restarts at addr 0.
